// File: rtl/ddr_axi_reader.sv
// AXI3 read-back engine for the DDR3 capture partition: splits a word-range command into
// INCR bursts of at most MAX_BURST beats and feeds the output FIFO. Option: DDR_RD_ABORT_EN.
//  state    | meaning
//  S_IDLE   | wait for start
//  S_CALC   | size next burst, wait for FIFO room
//  S_AR     | address phase
//  S_RDATA  | collect beats into the FIFO
//  S_SETTLE | let the FIFO fill level catch up
//  S_DONE   | completion pulse
module ddr_axi_reader #(
   parameter logic [31:0] DDR3_BASE_ADDR = 32'h3000_0000,
   parameter int          OFIFO_DEPTH    = 2048,
   parameter int          MAX_BURST      = 16
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        start,
   input  logic [25:0] start_word_addr,
   input  logic [19:0] word_count,
   output logic        busy,
   output logic        done,
   output logic        rd_err,
   output logic [31:0] m_axi_araddr,
   output logic [5:0]  m_axi_arid,
   output logic [3:0]  m_axi_arlen,
   output logic [2:0]  m_axi_arsize,
   output logic [1:0]  m_axi_arburst,
   output logic [3:0]  m_axi_arcache,
   output logic [1:0]  m_axi_arlock,
   output logic [2:0]  m_axi_arprot,
   output logic [3:0]  m_axi_arqos,
   output logic        m_axi_arvalid,
   input  logic        m_axi_arready,
   input  logic [31:0] m_axi_rdata,
   input  logic [5:0]  m_axi_rid,
   input  logic [1:0]  m_axi_rresp,
   input  logic        m_axi_rlast,
   input  logic        m_axi_rvalid,
   output logic        m_axi_rready,
   output logic [31:0] ofifo_din,
   output logic        ofifo_wr,
   input  logic [11:0] ofifo_wrcount
`ifdef DDR_RD_ABORT_EN
  ,input  logic        abort,
   output logic        aborted
`endif
);

   typedef enum logic [2:0] {S_IDLE, S_CALC, S_AR, S_RDATA, S_SETTLE, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [25:0] addr_q, addr_d;
   logic [19:0] remaining_q, remaining_d;
   logic [3:0]  beat_q, beat_d;
   logic        settle_q, settle_d;
   logic [3:0]  arlen_q, arlen_d;
   logic [31:0] araddr_q, araddr_d;
   logic [5:0]  arid_q, arid_d;
   logic        arvalid_q, arvalid_d;
   logic        rd_err_q, rd_err_d;
   logic [31:0] ofifo_din_q, ofifo_din_d;
   logic        ofifo_wr_q, ofifo_wr_d;
`ifdef DDR_RD_ABORT_EN
   logic        abort_pend_q, abort_pend_d;
   logic        aborted_q, aborted_d;
`endif

   logic [4:0]  len_c;
   logic [26:0] rem_top_c;
   logic [10:0] page_c;
   logic [12:0] free_c;

   // Burst length: beat limit, words left, partition end, and 4 KB page end.
   always_comb begin
      rem_top_c = 27'h400_0000 - {1'b0, addr_q};
      page_c    = 11'd1024 - {1'b0, addr_q[9:0]};
      len_c     = 5'(MAX_BURST);
      if (remaining_q < 20'(len_c)) len_c = remaining_q[4:0];
      if (rem_top_c < 27'(len_c))   len_c = rem_top_c[4:0];
      if (page_c < 11'(len_c))      len_c = page_c[4:0];
      if (13'(ofifo_wrcount) >= 13'(OFIFO_DEPTH)) free_c = 13'd0;
      else                                         free_c = 13'(OFIFO_DEPTH) - 13'(ofifo_wrcount);
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      beat_d      = beat_q;
      settle_d    = settle_q;
      arlen_d     = arlen_q;
      araddr_d    = araddr_q;
      arid_d      = arid_q;
      arvalid_d   = arvalid_q;
      rd_err_d    = rd_err_q;
      ofifo_din_d = ofifo_din_q;
      ofifo_wr_d  = 1'b0;
`ifdef DDR_RD_ABORT_EN
      abort_pend_d = abort_pend_q;
      aborted_d    = aborted_q;
      if ((state_q == S_AR || state_q == S_RDATA || state_q == S_SETTLE) && abort)
         abort_pend_d = 1'b1;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d      = start_word_addr;
               remaining_d = word_count;
               rd_err_d    = 1'b0;
`ifdef DDR_RD_ABORT_EN
               abort_pend_d = 1'b0;
               aborted_d    = 1'b0;
`endif
               state_d     = (word_count == 20'd0) ? S_DONE : S_CALC;
            end
         end
         S_CALC: begin
`ifdef DDR_RD_ABORT_EN
            if (abort) begin
               aborted_d = 1'b1;
               state_d   = S_DONE;
            end else
`endif
            if (free_c >= 13'(len_c)) begin
               arlen_d   = 4'(len_c - 5'd1);
               araddr_d  = {DDR3_BASE_ADDR[31:28], addr_q, 2'b00};
               arid_d    = arid_q + 6'd1;
               arvalid_d = 1'b1;
               beat_d    = 4'd0;
               state_d   = S_AR;
            end
         end
         S_AR: begin
            if (m_axi_arready) begin
               arvalid_d = 1'b0;
               state_d   = S_RDATA;
            end
         end
         S_RDATA: begin
            if (m_axi_rvalid) begin
               ofifo_din_d = m_axi_rdata;
               ofifo_wr_d  = 1'b1;
               beat_d      = beat_q + 4'd1;
               remaining_d = remaining_q - 20'd1;
               addr_d      = addr_q + 26'd1;
               if (m_axi_rresp != 2'b00 || m_axi_rid != arid_q ||
                   m_axi_rlast != (beat_q == arlen_q))
                  rd_err_d = 1'b1;
               // Burst ends on the beat count; rlast only feeds the error flag.
               if (beat_q == arlen_q) begin
                  settle_d = 1'b0;
                  state_d  = S_SETTLE;
               end
            end
         end
         S_SETTLE: begin
            if (settle_q) begin
               state_d = (remaining_q != 20'd0) ? S_CALC : S_DONE;
`ifdef DDR_RD_ABORT_EN
               if (abort_pend_d) begin
                  aborted_d = 1'b1;
                  state_d   = S_DONE;
               end
`endif
            end else begin
               settle_d = 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         beat_q      <= '0;
         settle_q    <= 1'b0;
         arlen_q     <= '0;
         araddr_q    <= {DDR3_BASE_ADDR[31:28], 28'h0};
         arid_q      <= '0;
         arvalid_q   <= 1'b0;
         rd_err_q    <= 1'b0;
         ofifo_din_q <= '0;
         ofifo_wr_q  <= 1'b0;
`ifdef DDR_RD_ABORT_EN
         abort_pend_q <= 1'b0;
         aborted_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         beat_q      <= beat_d;
         settle_q    <= settle_d;
         arlen_q     <= arlen_d;
         araddr_q    <= araddr_d;
         arid_q      <= arid_d;
         arvalid_q   <= arvalid_d;
         rd_err_q    <= rd_err_d;
         ofifo_din_q <= ofifo_din_d;
         ofifo_wr_q  <= ofifo_wr_d;
`ifdef DDR_RD_ABORT_EN
         abort_pend_q <= abort_pend_d;
         aborted_q    <= aborted_d;
`endif
      end
   end

   assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done          = (state_q == S_DONE);
   assign rd_err        = rd_err_q;
   assign m_axi_araddr  = araddr_q;
   assign m_axi_arid    = arid_q;
   assign m_axi_arlen   = arlen_q;
   assign m_axi_arsize  = 3'b010;
   assign m_axi_arburst = 2'b01;
   assign m_axi_arcache = 4'b0011;
   assign m_axi_arlock  = 2'b00;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_arqos   = 4'b0000;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_rready  = (state_q == S_RDATA);
   assign ofifo_din     = ofifo_din_q;
   assign ofifo_wr      = ofifo_wr_q;
`ifdef DDR_RD_ABORT_EN
   assign aborted       = aborted_q;
`endif

endmodule
